// File: rtl/vram_pkg.sv
// Shared types and helpers for the simple-dual-port video RAM.
// Holds the clear FSM state enum, lane-count helpers and the byte-merge function.
package vram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Widest word the merge helper handles; callers zero-extend to this.
   localparam int MAX_W = 1024;
   localparam int MAX_B = MAX_W / 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int lanes(input int dw);
      return dw / 8;
   endfunction

   // Enabled bytes come from new_w, the rest from old_w.
   function automatic logic [MAX_W-1:0] byte_merge(
      input logic [MAX_W-1:0] old_w,
      input logic [MAX_W-1:0] new_w,
      input logic [MAX_B-1:0] be
   );
      logic [MAX_W-1:0] r;
      for (int i = 0; i < MAX_B; i++)
         r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-result pipeline: (RD_LAT-1) shift stages of {valid, data, lane} plus an output register.
// Ports: clk, rst, cap_* (captured read), rd_valid / rd_data / rd_lane_data (registered results).
module vram_rd_pipe #(
   parameter int DATA_W = 64,
   parameter int LANE_W = 3,
   parameter int RD_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_valid,
   input  logic [DATA_W-1:0] cap_data,
   input  logic [LANE_W-1:0] cap_lane,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [7:0]        rd_lane_data
);

   localparam int NS = RD_LAT - 1;
   localparam int NB = DATA_W / 8;

   logic              t_valid;
   logic [DATA_W-1:0] t_data;
   logic [LANE_W-1:0] t_lane;
   logic [7:0]        t_sel;

   if (NS == 0) begin : g_direct
      assign t_valid = cap_valid;
      assign t_data  = cap_data;
      assign t_lane  = cap_lane;
   end else begin : g_shift
      logic [NS-1:0]     v_q;
      logic [DATA_W-1:0] d_q [NS];
      logic [LANE_W-1:0] l_q [NS];

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= '0;
         end else begin
            v_q[0] <= cap_valid;
            for (int i = 1; i < NS; i++) v_q[i] <= v_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         d_q[0] <= cap_data;
         l_q[0] <= cap_lane;
         for (int i = 1; i < NS; i++) begin
            d_q[i] <= d_q[i-1];
            l_q[i] <= l_q[i-1];
         end
      end

      assign t_valid = v_q[NS-1];
      assign t_data  = d_q[NS-1];
      assign t_lane  = l_q[NS-1];
   end

   always_comb begin
      t_sel = '0;
      for (int i = 0; i < NB; i++)
         if (t_lane == LANE_W'(i)) t_sel = t_data[8*i +: 8];
   end

   // Data outputs only move on a valid result so they hold between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         rd_lane_data <= '0;
      end else begin
         rd_valid <= t_valid;
         if (t_valid) begin
            rd_data      <= t_data;
            rd_lane_data <= t_sel;
         end
      end
   end

endmodule

// File: rtl/vram_sdp_pipe.sv
// Simple-dual-port video RAM with byte-enable writes, write-first merge, pipelined reads and a clear engine.
// Ports: clk/rst, write port (wr_*), read port (rd_* in, rd_data/rd_lane_data/rd_valid out), clr_req, busy flags.
module vram_sdp_pipe import vram_pkg::*; #(
   parameter int                DATA_W         = 64,
   parameter int                ADDR_W         = 14,
   parameter int                DEPTH          = 12288,
   parameter int                RD_LAT         = 3,
   parameter int                CLEAR_ON_RESET = 1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
   localparam int LANE_W = (clog2(lanes(DATA_W)) > 0) ? clog2(lanes(DATA_W)) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [LANE_W-1:0]   rd_lane,
   output logic [DATA_W-1:0]   rd_data,
   output logic [7:0]          rd_lane_data,
   output logic                rd_valid,
   input  logic                clr_req,
   output logic                wr_reset_busy,
   output logic                rd_reset_busy
);

   if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_W || ADDR_W < 1 ||
       ADDR_W > 30 || DEPTH < 1 || DEPTH > (1 << ADDR_W) || RD_LAT < 1) begin : g_bad_params
      $fatal(1, "vram_sdp_pipe: illegal parameter combination");
   end

   localparam int                IDX_W  = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

   clr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy;

   assign busy          = (state_q == CLEAR);
   assign wr_reset_busy = busy;
   assign rd_reset_busy = busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we, wr_ok, rd_ok, rd_hit;
   logic              wr_in_range, rd_in_range;
   logic [DATA_W-1:0] rd_old, rd_word;

   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
   // The FSM may sit in CLEAR while rst is held; no memory writes then.
   assign clr_we      = busy && !rst;
   assign wr_ok       = wr_en && !busy && wr_in_range;
   assign rd_ok       = rd_en && !busy;

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt_q[IDX_W-1:0]] <= CLEAR_VALUE;
      end else if (wr_ok) begin
         for (int i = 0; i < DATA_W/8; i++)
            if (wr_be[i]) mem[wr_addr[IDX_W-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
      end
   end

   // Write-first: a same-cycle write to the read address is merged into the captured word.
   assign rd_hit  = wr_ok && (wr_addr == rd_addr);
   assign rd_old  = rd_in_range ? mem[rd_addr[IDX_W-1:0]] : CLEAR_VALUE;
   assign rd_word = rd_hit ? DATA_W'(byte_merge(MAX_W'(rd_old), MAX_W'(wr_data), MAX_B'(wr_be)))
                           : rd_old;

   vram_rd_pipe #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk          (clk),
      .rst          (rst),
      .cap_valid    (rd_ok),
      .cap_data     (rd_word),
      .cap_lane     (rd_lane),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_lane_data (rd_lane_data)
   );

endmodule

// File: tb/tb_vram_sdp_pipe.sv
// Scoreboard bench for vram_sdp_pipe: RD_LAT=3 main instance plus an RD_LAT=1 instance on shared inputs.
// Expected reads are queued at issue time and compared in order against observed rd_valid pulses.
module tb_vram_sdp_pipe;

   localparam int DW    = 64;
   localparam int AW    = 14;
   localparam int DEPTH = 12288;
   localparam int NB    = 8;
   localparam int LW    = 3;
   localparam int LIMIT = 20000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [NB-1:0] wr_be = '0;
   logic [DW-1:0] wr_data = '0;
   logic [LW-1:0] rd_lane = '0;

   logic [DW-1:0] rd_data, rd_data_1;
   logic [7:0]    rd_lane_data, rd_lane_data_1;
   logic          rd_valid, rd_valid_1;
   logic          wr_reset_busy, rd_reset_busy, wr_busy_1, rd_busy_1;

   vram_sdp_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(3),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE('0)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane),
      .rd_data(rd_data), .rd_lane_data(rd_lane_data), .rd_valid(rd_valid),
      .clr_req(clr_req), .wr_reset_busy(wr_reset_busy), .rd_reset_busy(rd_reset_busy)
   );

   vram_sdp_pipe #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1),
      .CLEAR_ON_RESET(1), .CLEAR_VALUE('0)
   ) dut1 (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane),
      .rd_data(rd_data_1), .rd_lane_data(rd_lane_data_1), .rd_valid(rd_valid_1),
      .clr_req(clr_req), .wr_reset_busy(wr_busy_1), .rd_reset_busy(rd_busy_1)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned c;
      logic [63:0] d;
      logic [7:0]  l;
   } rec_t;

   rec_t exp_q[$], obs3[$], obs1[$], saved[$];
   rec_t e, o;
   int   n_cmp = 0, n_bad = 0;
   int   n;

   always @(negedge clk) begin
      if (rd_valid)   obs3.push_back('{cyc, rd_data, rd_lane_data});
      if (rd_valid_1) obs1.push_back('{cyc, rd_data_1, rd_lane_data_1});
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_set(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
   endtask

   task automatic rd_set(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [DW-1:0] d);
      rd_en   = 1'b1;
      rd_addr = a;
      rd_lane = l;
      exp_q.push_back('{cyc, d, 8'(d >> (8 * l))});
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (4) tick();
      n_cmp++;
      if ({rd_valid, rd_data, rd_lane_data} !== 73'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b data=%h lane=%h, want all 0",
                  rd_valid, rd_data, rd_lane_data);
      end
      n_cmp++;
      if ({wr_reset_busy, rd_reset_busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL reset_busy: got %b%b, want 11", wr_reset_busy, rd_reset_busy);
      end
   endtask

   task automatic test_clear_on_reset();
      rst = 1'b0;
      n = 0;
      while (wr_reset_busy === 1'b1 && n < LIMIT) begin
         n++;
         tick();
      end
      n_cmp++;
      if (n != DEPTH || rd_reset_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_len: got %0d busy cycles (rd_busy=%b), want %0d", n, rd_reset_busy, DEPTH);
      end
      rd_set(14'd0, 3'd0, 64'd0);
      tick();
      rd_set(14'd12287, 3'd7, 64'd0);
      tick();
      idle();
      repeat (4) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL clear_read: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL clear_read: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      obs1.delete();
   endtask

   task automatic test_write_lane();
      wr_set(14'd5, 64'h0102030405060708, 8'hFF);
      tick();
      idle();
      rd_set(14'd5, 3'd2, 64'h0102030405060708);
      tick();
      idle();
      repeat (4) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL write_lane: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL write_lane: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      obs1.delete();
   endtask

   task automatic test_collision();
      wr_set(14'd9, 64'h1111111111111111, 8'hFF);
      tick();
      wr_set(14'd9, 64'hAAAAAAAABBBBBBBB, 8'h0F);
      rd_set(14'd9, 3'd4, 64'h11111111BBBBBBBB);
      tick();
      rd_en = 1'b0;
      wr_set(14'd9, 64'h2222222222222222, 8'hFF);
      tick();
      idle();
      rd_set(14'd9, 3'd1, 64'h2222222222222222);
      tick();
      idle();
      repeat (4) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL collision: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL collision: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      obs1.delete();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         wr_set(AW'(i), DW'(i), 8'hFF);
         tick();
      end
      idle();
      obs1.delete();
      for (int i = 0; i < 8; i++) begin
         rd_set(AW'(i), 3'd0, DW'(i));
         tick();
      end
      idle();
      repeat (4) tick();
      saved = exp_q;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_lat3: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL b2b_lat3: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      while (saved.size() > 0) begin
         e = saved.pop_front();
         n_cmp++;
         if (obs1.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_lat1: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 1);
         end else begin
            o = obs1.pop_front();
            if (o.c !== e.c + 1 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL b2b_lat1: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 1, e.d, e.l);
            end
         end
      end
      n_cmp++;
      if (obs3.size() != 0 || obs1.size() != 0) begin
         n_bad++;
         $display("FAIL b2b_extra: got %0d/%0d extra pulses, want 0/0", obs3.size(), obs1.size());
      end
      obs3.delete();
      obs1.delete();
   endtask

   task automatic test_clear_restart();
      rd_set(14'd7, 3'd0, 64'd7);
      clr_req = 1'b1;
      tick();
      idle();
      repeat (100) tick();
      n_cmp++;
      if (wr_reset_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL clr_req_busy: got %b, want 1", wr_reset_busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n = 0;
      while (wr_reset_busy === 1'b1 && n < LIMIT) begin
         if (n == DEPTH - 10) begin
            wr_set(14'd20, 64'hDEADBEEFCAFEF00D, 8'hFF);
            rd_en   = 1'b1;
            rd_addr = 14'd20;
         end else begin
            idle();
         end
         n++;
         tick();
      end
      idle();
      n_cmp++;
      if (n != DEPTH) begin
         n_bad++;
         $display("FAIL restart_len: got %0d busy cycles, want %0d", n, DEPTH);
      end
      rd_set(14'd20, 3'd0, 64'd0);
      tick();
      rd_set(14'd3, 3'd0, 64'd0);
      tick();
      idle();
      repeat (4) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL restart_read: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL restart_read: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      n_cmp++;
      if (obs3.size() != 0) begin
         n_bad++;
         $display("FAIL restart_extra: got %0d extra rd_valid pulses, want 0", obs3.size());
      end
      obs3.delete();
      obs1.delete();
   endtask

   task automatic test_out_of_range();
      wr_set(14'd0, 64'hA000000000000000, 8'hFF);
      tick();
      wr_set(14'd12, 64'h00000000000000A1, 8'hFF);
      tick();
      wr_set(14'd12287, 64'h00000000A2000000, 8'hFF);
      tick();
      wr_set(14'd12300, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      tick();
      idle();
      rd_set(14'd12288, 3'd0, 64'd0);
      tick();
      rd_set(14'd0, 3'd7, 64'hA000000000000000);
      tick();
      rd_set(14'd12, 3'd0, 64'h00000000000000A1);
      tick();
      rd_set(14'd12287, 3'd3, 64'h00000000A2000000);
      tick();
      idle();
      repeat (4) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (obs3.size() == 0) begin
            n_bad++;
            $display("FAIL out_of_range: no rd_valid, want data=%h at cycle %0d", e.d, e.c + 3);
         end else begin
            o = obs3.pop_front();
            if (o.c !== e.c + 3 || o.d !== e.d || o.l !== e.l) begin
               n_bad++;
               $display("FAIL out_of_range: got cyc=%0d data=%h lane=%h, want cyc=%0d data=%h lane=%h",
                        o.c, o.d, o.l, e.c + 3, e.d, e.l);
            end
         end
      end
      obs1.delete();
   endtask

   initial begin
      test_reset();
      test_clear_on_reset();
      test_write_lane();
      test_collision();
      test_back_to_back();
      test_clear_restart();
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
